txn_sample_buffer: RTL



---
 rtl/txn_sample_buffer_if.sv | 37 +++
 rtl/txn_sample_buffer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/txn_sample_buffer_if.sv
// Bundle of configuration, channel-monitor and FIFO-head signals for txn_sample_buffer.
// The master side drives configuration, channel beats and pop; the slave side is the sampler.
interface txn_sample_buffer_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int PW  = 3,
  parameter int AW  = 3,
  parameter int CW  = 16
);
  logic                       clr;
  logic                       cfg_en;
  logic                       cfg_mode;
  logic [NCH*(2**PW)-1:0]     cfg_mask;
  logic [NCH-1:0]             ch_vld;
  logic [NCH*DW-1:0]          ch_data;
  logic [NCH*PW-1:0]          ch_attr;
  logic                       pop;
  logic                       out_vld;
  logic [DW-1:0]              out_data;
  logic [$clog2(NCH)-1:0]     out_ch;
  logic [PW-1:0]              out_attr;
  logic [AW:0]                level;
  logic                       full;
  logic                       empty;
  logic                       ovf;
  logic [CW-1:0]              drop_cnt;

  modport master (
    output clr, cfg_en, cfg_mode, cfg_mask, ch_vld, ch_data, ch_attr, pop,
    input  out_vld, out_data, out_ch, out_attr, level, full, empty, ovf, drop_cnt
  );

  modport slave (
    input  clr, cfg_en, cfg_mode, cfg_mask, ch_vld, ch_data, ch_attr, pop,
    output out_vld, out_data, out_ch, out_attr, level, full, empty, ovf, drop_cnt
  );
endinterface

// File: rtl/txn_sample_buffer.sv
// Multi-channel beat sampler: lowest-index arbitration into a show-ahead FIFO with
// stop-on-full / overwrite-oldest modes and a saturating lost-sample counter.
module txn_sample_buffer #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int PW  = 3,
  parameter int AW  = 3,
  parameter int CW  = 16
) (
  input logic              clk,
  input logic              rst,
  txn_sample_buffer_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam int NA    = 2**PW;
  localparam int CHW   = $clog2(NCH);
  localparam int LW    = $clog2(NCH + 1) + 1;

  function automatic logic [LW-1:0] count_ones(input logic [NCH-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + LW'(v[i]);
    end
    return n;
  endfunction

  logic [DW-1:0]  mem_data [DEPTH];
  logic [CHW-1:0] mem_ch   [DEPTH];
  logic [PW-1:0]  mem_attr [DEPTH];

  logic [AW-1:0]  wr_r, rd_r;
  logic [AW:0]    level_r, level_nx_s;
  logic [CW-1:0]  drop_r, drop_nx_s;
  logic           ovf_r;

  logic [NCH-1:0] q_s;
  logic           any_s;
  logic [CHW-1:0] win_s;
  logic [DW-1:0]  win_data_s;
  logic [PW-1:0]  win_attr_s;
  logic           empty_s, full_s, pop_ok_s, ovw_s, lost_win_s, push_s;
  logic           inc_s, dec_s;
  logic [LW-1:0]  loss_s;
  logic [CW+LW-1:0] sum_s;

  // Qualify each channel against enable, valid and its per-attribute mask bit.
  always_comb begin
    q_s = '0;
    for (int c = 0; c < NCH; c++) begin
      q_s[c] = bus.cfg_en & bus.ch_vld[c] & bus.cfg_mask[c*NA + int'(bus.ch_attr[c*PW +: PW])];
    end
  end

  // Lowest qualifying index wins; scanning downward leaves the lowest one standing.
  always_comb begin
    win_s = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      win_s = q_s[c] ? CHW'(c) : win_s;
    end
    any_s      = |q_s;
    win_data_s = bus.ch_data[int'(win_s)*DW +: DW];
    win_attr_s = bus.ch_attr[int'(win_s)*PW +: PW];
  end

  // Push/pop decisions, loss accounting and next level / counter values.
  always_comb begin
    empty_s    = (level_r == (AW+1)'(0));
    full_s     = (level_r == (AW+1)'(DEPTH));
    pop_ok_s   = bus.pop & ~empty_s;
    ovw_s      = any_s & full_s & ~pop_ok_s & bus.cfg_mode;
    lost_win_s = any_s & full_s & ~pop_ok_s & ~bus.cfg_mode;
    push_s     = any_s & ~lost_win_s;
    inc_s      = push_s & ~pop_ok_s & ~ovw_s;
    dec_s      = pop_ok_s & ~push_s;
    if (any_s) begin
      loss_s = count_ones(q_s) - LW'(1);
    end else begin
      loss_s = '0;
    end
    loss_s = loss_s + LW'(lost_win_s) + LW'(ovw_s);

    case ({inc_s, dec_s})
      2'b10:   level_nx_s = level_r + (AW+1)'(1);
      2'b01:   level_nx_s = level_r - (AW+1)'(1);
      default: level_nx_s = level_r;
    endcase

    sum_s = (CW+LW)'(drop_r) + (CW+LW)'(loss_s);
    if (sum_s > (CW+LW)'({CW{1'b1}})) begin
      drop_nx_s = {CW{1'b1}};
    end else begin
      drop_nx_s = sum_s[CW-1:0];
    end
  end

  // Storage array, deliberately unreset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_s && !bus.clr && !rst) begin
      mem_data[wr_r] <= win_data_s;
      mem_ch[wr_r]   <= win_s;
      mem_attr[wr_r] <= win_attr_s;
    end
  end

  // Pointers, occupancy and loss bookkeeping; clr dominates any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= '0;
      rd_r    <= '0;
      level_r <= '0;
      drop_r  <= '0;
      ovf_r   <= 1'b0;
    end else if (bus.clr) begin
      wr_r    <= '0;
      rd_r    <= '0;
      level_r <= '0;
      drop_r  <= '0;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_r <= wr_r + AW'(1);
      end
      if (pop_ok_s || ovw_s) begin
        rd_r <= rd_r + AW'(1);
      end
      level_r <= level_nx_s;
      drop_r  <= drop_nx_s;
      if (loss_s != LW'(0)) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.level    = level_r;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.out_vld  = ~empty_s;
  assign bus.ovf      = ovf_r;
  assign bus.drop_cnt = drop_r;
  assign bus.out_data = empty_s ? '0 : mem_data[rd_r];
  assign bus.out_ch   = empty_s ? '0 : mem_ch[rd_r];
  assign bus.out_attr = empty_s ? '0 : mem_attr[rd_r];
endmodule
